mult_booth_seq: RTL
===================

// Module: mult_booth_seq
// PURPOSE
//  Sequencer directly upstream of the radix-4 Booth step (mult_booth). Latches operands on ctrl_MULT.
//  Seeds the step's 65-bit product word, then feeds its registered product back for 16 iterations.
//  Extracts the 32-bit result, flags overflow and pulses data_resultRDY; sits inside multdiv.
// PARAMETERS
//  WIDTH   32  operand/result width; only 32 is supported (mult_booth is fixed width)
//  STEPS   16  Booth iterations = WIDTH/2
//  CNT_W   5   iteration counter width, must hold STEPS
// PORTS
//  clock              in   1   single clock, rising edge
//  reset              in   1   synchronous, active-high
//  ctrl_MULT          in   1   start pulse; operands valid in the same cycle
//  data_operandA      in   32  multiplicand (signed)
//  data_operandB      in   32  multiplier (signed)
//  step_product       in   65  registered product from mult_booth
//  step_prev_product  out  65  to mult_booth prev_product
//  step_multiplicand  out  32  to mult_booth multiplicand
//  data_result        out  32  signed 32-bit product, held until next start
//  data_exception     out  1   overflow flag, valid with/after data_resultRDY
//  data_resultRDY     out  1   one-cycle pulse when result is valid
//  busy               out  1   high while iterating
// BEHAVIOUR
//  Reset (sync, reset=1 at an edge):
//   - state<=IDLE, cnt<=0; data_result, data_exception, data_resultRDY, busy all <=0.
//   - Regs A_q, B_q <=0; dominates ctrl_MULT in the same cycle.
//  States: IDLE, RUN, DONE.
//   - IDLE->RUN on ctrl_MULT.
//   - RUN->DONE at the edge where cnt==STEPS.
//   - DONE->IDLE next edge.
//   - ctrl_MULT in any state (incl. RUN, DONE) restarts: new operands, cnt<=1, state<=RUN.
//  Step drive (combinational):
//   - ctrl_MULT=1: step_prev_product={32'b0, data_operandB, 1'b0}, step_multiplicand=data_operandA.
//   - RUN and !ctrl_MULT: step_prev_product=step_product, step_multiplicand=A_q.
//   - otherwise: both driven 0. The step then holds 0 (ctrl bits 000 add 0).
//  Counting:
//   - start edge: A_q<=data_operandA, B_q<=data_operandB, cnt<=1 (step latched iteration 1).
//   - RUN: cnt<=cnt+1 each edge while cnt<STEPS.
//   - After edge k, step_product holds k iterations.
//  Completion, at the edge with state==RUN && cnt==STEPS && !ctrl_MULT:
//   - data_result<=step_product[32:1]; data_resultRDY<=1 (low on all other edges); busy<=0.
//   - Start at cycle 0 gives RDY high in cycle 17, with result stable from cycle 17 until next start.
//  Overflow rules:
//   - data_exception<=1 if step_product[64:32] is not all-equal (64-bit product not sign-extended).
//   - Also forced 1 when A_q==32'h8000_0000 and B_q is not 0 or 1. This covers the step's 32-bit adder
//     wrap on -2^31*2; the forced term is ORed with the sign check.
//   - data_exception cleared on start.
//  busy:
//   - 1 from the start edge through the completion edge.
//   - Restart mid-RUN aborts with no RDY for the aborted op.
//  Reset mid-RUN: IDLE next cycle, no RDY, step drive 0; step_product settles to 0 within 1 cycle.
//  ctrl_MULT asserted in the completion cycle: restart wins, no RDY.
// TESTING
//  1. reset; A=3, B=5, ctrl_MULT @cyc0 -> RDY only in cyc17, data_result=15, exception=0, busy cyc1..16
//  2. A=-7, B=6 -> result=32'hFFFF_FFD6, exception=0; A=-1, B=-1 -> result=1, exception=0
//  3. A=32'h0001_0000, B=32'h0001_0000 -> result=0, exception=1; A=32'h8000_0000, B=-1 -> exception=1;
//     A=32'h8000_0000, B=1 -> result=32'h8000_0000, exception=0
//  4. start 3*5, re-pulse ctrl_MULT @cyc8 with 4*4 -> single RDY at cyc25, result=16
//  5. start 3*5, reset @cyc10 -> no RDY, outputs 0, busy=0 @cyc11; new 2*2 gives RDY 17 cycles later, result 4
//  6. back-to-back: ctrl_MULT in cyc17 with 9*9 -> result 15 held cyc17, RDY pulse cyc34 with 81

Source files
------------

// File: rtl/mult_booth_seq.sv
// Sequencer for the radix-4 Booth step: seeds the 65-bit product word, iterates it STEPS times
// through the external step register, then extracts the 32-bit result and an overflow flag.
module mult_booth_seq #(
  parameter int WIDTH = 32,
  parameter int STEPS = 16,
  parameter int CNT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_MULT,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  input  logic [2*WIDTH:0]   step_product,
  output logic [2*WIDTH:0]   step_prev_product,
  output logic [WIDTH-1:0]   step_multiplicand,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_exception,
  output logic               data_resultRDY,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(STEPS);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic signed [WIDTH-1:0] a_q;
  logic signed [WIDTH-1:0] b_q;

  // The step's adder is only WIDTH bits wide, so -2^31 times anything other than 0 or 1
  // can wrap without leaving a visible trace in the upper product bits.
  function automatic logic ovf_detect(input logic [2*WIDTH:0] prod,
                                      input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
    logic [WIDTH:0] hi;
    logic           sign_bad;
    logic           min_wrap;
    hi       = prod[2*WIDTH:WIDTH];
    sign_bad = !((hi == '0) || (hi == '1));
    min_wrap = (a == MIN_NEG) && (b != '0) && (b != ONE);
    return sign_bad || min_wrap;
  endfunction

  always_comb begin
    step_prev_product = '0;
    step_multiplicand = '0;
    if (ctrl_MULT) begin
      step_prev_product = {{WIDTH{1'b0}}, data_operandB, 1'b0};
      step_multiplicand = data_operandA;
    end else if (state == RUN) begin
      step_prev_product = step_product;
      step_multiplicand = a_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      a_q            <= '0;
      b_q            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        // The step register latches iteration 1 on this same edge.
        a_q            <= data_operandA;
        b_q            <= data_operandB;
        cnt            <= CNT_W'(1);
        state          <= RUN;
        busy           <= 1'b1;
        data_exception <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (cnt == CNT_END) begin
              data_result    <= step_product[WIDTH:1];
              data_exception <= ovf_detect(step_product, a_q, b_q);
              data_resultRDY <= 1'b1;
              busy           <= 1'b0;
              state          <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
